// File: rtl/hex_keypad_encoder_pkg.sv
// keypad_pkg: shared types and constants for the hex keypad encoder.
// Holds the FSM state type, the row/column key map and the column-drive helper.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        PRESSED,
        RELEASE_DB
    } kp_state_t;

    // KEY_MAP[row][col] -> hex nibble, same 0-F encoding as the display path.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // One-hot seed for the active-low column drive.
    localparam logic [3:0] COL_ONE_HOT = 4'b0001;

    // Active-low column drive for a given column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(COL_ONE_HOT << idx);
    endfunction

    // Index of the lowest-numbered low row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && !rows[i]) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_keypad_encoder_if.sv
// hex_keypad_encoder_if: keypad pins plus the encoded key output bundle.
// master = encoder side, slave = keypad/consumer side.
interface hex_keypad_encoder_if;

    logic [3:0] ROW;       // keypad rows, active-low, asynchronous
    logic [3:0] COL;       // column drive, active-low, one bit low
    logic [3:0] KeyCode;   // last accepted key
    logic       KeyValid;  // one-cycle strobe per accept/repeat
    logic       KeyHeld;   // high from accept until debounced release

    modport master (
        input  ROW,
        output COL,
        output KeyCode,
        output KeyValid,
        output KeyHeld
    );

    modport slave (
        output ROW,
        input  COL,
        input  KeyCode,
        input  KeyValid,
        input  KeyHeld
    );

endinterface

// File: rtl/hex_keypad_encoder_sync2.sv
// keypad_sync2: 4-bit two-flop synchroniser for the asynchronous keypad rows.
// Resets to all-ones so an idle (pulled-up) keypad reads as no key.
module keypad_sync2 (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Two-stage capture of the raw row pins.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hex_keypad_encoder.sv
// hex_keypad_encoder: scans a 4x4 hex keypad, debounces press and release,
// and emits the key nibble with a one-cycle KeyValid strobe.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat strobes while held).
module hex_keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 500000,
    parameter int unsigned REPEAT_DLY   = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input logic                  Clock,
    input logic                  Reset_n,
    hex_keypad_encoder_if.master kp
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT);

    // Settle time in the scan slot and non-adjacent repeat strobes need these.
    if (SCAN_DIV < 3 || DEBOUNCE_CNT < 1 || REPEAT_DLY < 2 || REPEAT_RATE < 2) begin : g_param_check
        $error("hex_keypad_encoder: parameter out of range");
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    localparam logic [REP_W-1:0] REP_DLY_LAST  = REP_W'(REPEAT_DLY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_first_q;  // still waiting for the initial delay
`endif

    kp_state_t         state_q;
    logic [1:0]        col_idx_q;
    logic [1:0]        row_idx_q;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [3:0]        key_code_q;
    logic              key_valid_q;
    logic              key_held_q;

    logic [3:0]        rows_s;
    logic              row_up;

    keypad_sync2 u_sync (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .d_i     (kp.ROW),
        .q_o     (rows_s)
    );

    // Latched row of the key being tracked reads released (high).
    assign row_up = rows_s[row_idx_q];

    // Scan / debounce FSM with registered outputs and per-state counters.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            scan_cnt_q  <= '0;
            db_cnt_q    <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
`endif
        end else begin
            key_valid_q <= 1'b0;
            unique case (state_q)
                SCAN: begin
                    if (scan_cnt_q == SCAN_LAST) begin
                        scan_cnt_q <= '0;
                        if (rows_s != 4'hF) begin
                            row_idx_q <= lowest_low_row(rows_s);
                            db_cnt_q  <= '0;
                            state_q   <= PRESS_DB;
                        end else begin
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end else begin
                        scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
                    end
                end

                PRESS_DB: begin
                    if (row_up) begin
                        scan_cnt_q <= '0;
                        db_cnt_q   <= '0;
                        state_q    <= SCAN;
                    end else if (db_cnt_q == DB_LAST) begin
                        key_code_q  <= KEY_MAP[row_idx_q][col_idx_q];
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        db_cnt_q    <= '0;
                        state_q     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end

                PRESSED: begin
                    if (row_up) begin
                        db_cnt_q <= '0;
                        state_q  <= RELEASE_DB;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_first_q ? (rep_cnt_q == REP_DLY_LAST)
                                         : (rep_cnt_q == REP_RATE_LAST)) begin
                        key_valid_q <= 1'b1;
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b0;
                    end else begin
                        rep_cnt_q <= rep_cnt_q + REP_W'(1);
                    end
`endif
                end

                RELEASE_DB: begin
                    if (!row_up) begin
                        db_cnt_q <= '0;
                        state_q  <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_q   <= '0;
                        rep_first_q <= 1'b1;
`endif
                    end else if (db_cnt_q == DB_LAST) begin
                        key_held_q <= 1'b0;
                        col_idx_q  <= col_idx_q + 2'd1;
                        scan_cnt_q <= '0;
                        db_cnt_q   <= '0;
                        state_q    <= SCAN;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
            endcase
        end
    end

    assign kp.COL      = col_drive(col_idx_q);
    assign kp.KeyCode  = key_code_q;
    assign kp.KeyValid = key_valid_q;
    assign kp.KeyHeld  = key_held_q;

endmodule

// File: tb/tb_hex_keypad_encoder.sv
// tb_hex_keypad_encoder: directed scenarios against a behavioural keypad model.
// Define KEYPAD_REPEAT_EN for both RTL and bench to exercise auto-repeat.
module tb_hex_keypad_encoder;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int RDLY     = 40;
    localparam int RRATE    = 10;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    hex_keypad_encoder_if kp ();

    hex_keypad_encoder #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB),
        .REPEAT_DLY   (RDLY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .kp      (kp)
    );

    always #5 clk = ~clk;

    // Physical keypad: bit r*4+c set means the key at row r, column c is closed.
    logic [15:0] pressed = '0;

    function automatic logic [3:0] pins(input logic [3:0] col, input logic [15:0] keys);
        logic [3:0] p;
        p = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) p[r] = 1'b0;
        return p;
    endfunction

    assign kp.ROW = pins(kp.COL, pressed);

    function automatic logic [3:0] colvec(input int c);
        logic [3:0] v;
        v    = 4'hF;
        v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic [3:0] key_of(input int r, input int c);
        string s;
        byte   ch;
        s  = "123A456B789CE0FD";
        ch = s[r*4+c];
        if (ch >= "A") return 4'(ch - "A" + 10);
        return 4'(ch - "0");
    endfunction

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 scanning, 1 confirming press, 2 held, 3 confirming release.
    int         cyc    = 0;
    int         m_mode = 0;
    int         m_t    = 0;
    int         m_col  = 0;
    int         m_row  = 0;
    int         t_hold = 0;
    logic [3:0] m_code = 4'h0;
    logic       m_valid = 1'b0;
    logic       m_held  = 1'b0;
    logic [3:0] s1 = 4'hF;
    logic [3:0] s2 = 4'hF;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = 0; m_t = 0; m_col = 0; m_row = 0;
                m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
                s1 = 4'hF; s2 = 4'hF;
            end else begin
                logic [3:0] pin;
                int         dt;
                logic       found;
                cyc++;
                pin     = pins(colvec(m_col), pressed);
                m_valid = 1'b0;
                case (m_mode)
                    0: begin
                        if (m_t == SCAN_DIV - 1) begin
                            m_t = 0;
                            if (s2 != 4'hF) begin
                                found = 1'b0;
                                for (int r = 0; r < 4; r++)
                                    if (!found && !s2[r]) begin m_row = r; found = 1'b1; end
                                m_mode = 1;
                            end else begin
                                m_col = (m_col + 1) % 4;
                            end
                        end else begin
                            m_t++;
                        end
                    end
                    1: begin
                        if (s2[m_row]) begin
                            m_mode = 0; m_t = 0;
                        end else if (m_t == DEB) begin
                            m_code = key_of(m_row, m_col); m_valid = 1'b1; m_held = 1'b1;
                            m_mode = 2; m_t = 0; t_hold = cyc;
                        end else begin
                            m_t++;
                        end
                    end
                    2: begin
                        if (s2[m_row]) begin
                            m_mode = 3; m_t = 0;
                        end else begin
                            dt = cyc - t_hold;
                            if (REP_EN && (dt == RDLY || (dt > RDLY && (dt - RDLY) % RRATE == 0)))
                                m_valid = 1'b1;
                        end
                    end
                    default: begin
                        if (!s2[m_row]) begin
                            m_mode = 2; m_t = 0; t_hold = cyc;
                        end else if (m_t == DEB) begin
                            m_held = 1'b0; m_col = (m_col + 1) % 4; m_mode = 0; m_t = 0;
                        end else begin
                            m_t++;
                        end
                    end
                endcase
                s2 = s1;
                s1 = pin;
            end
        end
    end

    // Cycle-by-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("COL", 32'(kp.COL), 32'(colvec(m_col)));
            chk("KeyCode", 32'(kp.KeyCode), 32'(m_code));
            chk("KeyValid", 32'(kp.KeyValid), 32'(m_valid));
            chk("KeyHeld", 32'(kp.KeyHeld), 32'(m_held));
            if (rst_n && kp.KeyValid) strobes++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (kp.KeyValid) break;
        end
        chk(name, 32'(kp.KeyValid), 32'd1);
    endtask

    task automatic wait_mode(input string name, input int mode, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_mode == mode) break;
            tick(1);
        end
        chk(name, 32'(m_mode), 32'(mode));
    endtask

    task automatic wait_held_low(input string name, input int budget, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (kp.KeyHeld && n < budget);
        chk(name, 32'(kp.KeyHeld), 32'd0);
    endtask

    initial begin
        logic [3:0] walk [4];
        int         s0;
        int         n;
        walk = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        #1 rst_n = 1'b0;
        tick(3);
        chk("rst_COL", 32'(kp.COL), 32'h0E);
        chk("rst_KeyCode", 32'(kp.KeyCode), 32'h0);
        chk("rst_KeyValid", 32'(kp.KeyValid), 32'h0);
        chk("rst_KeyHeld", 32'(kp.KeyHeld), 32'h0);
        rst_n = 1'b1;

        // Idle scan: column advances every SCAN_DIV cycles.
        for (int k = 0; k < 4; k++) begin
            tick(4);
            chk("col_walk", 32'(kp.COL), 32'(walk[k]));
        end

        // Clean press r2,c1 -> 8; release latency 2 sync + 9 debounce + 1 sample edge.
        s0 = strobes;
        pressed[2*4+1] = 1'b1;
        wait_valid("press_r2c1", 100);
        chk("code_r2c1", 32'(kp.KeyCode), 32'h8);
        chk("held_r2c1", 32'(kp.KeyHeld), 32'h1);
        tick(1);
        chk("valid_single", 32'(kp.KeyValid), 32'h0);
        tick(5);
        pressed = '0;
        wait_held_low("release_r2c1", 60, n);
        chk("release_latency", 32'(n), 32'd12);
        chk("resume_col2", 32'(kp.COL), 32'b1011);
        chk("strobes_r2c1", 32'(strobes - s0), 32'd1);

        // Press bounce on r0,c3: glitch restarts debounce, then one strobe with A.
        s0 = strobes;
        pressed[0*4+3] = 1'b1;
        wait_mode("enter_press_db", 1, 100);
        tick(5);
        pressed[0*4+3] = 1'b0;
        tick(1);
        pressed[0*4+3] = 1'b1;
        tick(2);
        chk("bounce_back_scan", 32'(m_mode), 32'd0);
        chk("bounce_no_strobe", 32'(strobes - s0), 32'd0);
        wait_valid("press_r0c3", 100);
        chk("code_r0c3", 32'(kp.KeyCode), 32'hA);
        chk("strobes_r0c3", 32'(strobes - s0), 32'd1);
        pressed = '0;
        wait_held_low("release_r0c3", 60, n);

        // Priority in column 0: r1 beats r3; a second key while held is ignored.
        s0 = strobes;
        pressed[1*4+0] = 1'b1;
        pressed[3*4+0] = 1'b1;
        wait_valid("press_prio", 100);
        chk("code_prio", 32'(kp.KeyCode), 32'h4);
        pressed[0*4+2] = 1'b1;
        tick(30);
        chk("no_rollover", 32'(strobes - s0), 32'd1);
        chk("held_prio", 32'(kp.KeyHeld), 32'h1);

        // Release bounce: low glitch during release debounce keeps KeyHeld up.
        pressed = '0;
        wait_mode("enter_release_db", 3, 20);
        tick(3);
        pressed[1*4+0] = 1'b1;
        tick(1);
        pressed[1*4+0] = 1'b0;
        tick(7);
        chk("rel_bounce_held", 32'(kp.KeyHeld), 32'h1);
        wait_held_low("release_prio", 60, n);
        chk("rel_bounce_no_strobe", 32'(strobes - s0), 32'd1);

        // Hold r3,c0: E, repeats at +40/+50/+60 only with auto-repeat.
        s0 = strobes;
        pressed[3*4+0] = 1'b1;
        wait_valid("press_r3c0", 100);
        chk("code_r3c0", 32'(kp.KeyCode), 32'hE);
        tick(40);
        chk("repeat_40", 32'(kp.KeyValid), 32'(REP_EN));
        tick(10);
        chk("repeat_50", 32'(kp.KeyValid), 32'(REP_EN));
        tick(10);
        chk("repeat_60", 32'(kp.KeyValid), 32'(REP_EN));
        chk("code_repeat", 32'(kp.KeyCode), 32'hE);
        tick(5);
        chk("strobes_hold", 32'(strobes - s0), REP_EN ? 32'd4 : 32'd1);

        // Reset mid-hold aborts at once.
        rst_n = 1'b0;
        #1;
        chk("abort_COL", 32'(kp.COL), 32'h0E);
        chk("abort_KeyCode", 32'(kp.KeyCode), 32'h0);
        chk("abort_KeyValid", 32'(kp.KeyValid), 32'h0);
        chk("abort_KeyHeld", 32'(kp.KeyHeld), 32'h0);
        tick(2);
        pressed = '0;
        rst_n = 1'b1;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
